// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link receiver: FSM states, bit-order
// constants agreed with the PISO transmitter, and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam bit BIT_MSB_FIRST = 1'b1;
  localparam bit BIT_LSB_FIRST = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Mod-WIDTH bit counter: clear loads 0, restart loads 1, inc advances and wraps.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inc,
  input  logic                            restart,
  input  logic                            clear,
  output logic [cnt_width(WIDTH)-1:0]     cnt,
  output logic                            tc_c
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] TC = CW'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
    end
  end

  assign tc_c = (cnt == TC);

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out deserializer: one qualified bit per clock into
// WIDTH-bit words, with sof-based framing and misalignment flagging.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = BIT_MSB_FIRST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic                        data_in,
  input  logic                        sof,
  output logic [WIDTH-1:0]            data_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        frame_err
);

  state_e           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] data_n;
  logic             out_valid_n, frame_err_n, busy_n;
  logic             cnt_inc, cnt_restart, cnt_clear, cnt_tc_c;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                input logic             b);
    if (MSB_FIRST == BIT_MSB_FIRST) return {s[WIDTH-2:0], b};
    else                            return {b, s[WIDTH-1:1]};
  endfunction

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .restart (cnt_restart),
    .clear   (cnt_clear),
    .cnt     (bit_cnt),
    .tc_c    (cnt_tc_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      out_valid <= out_valid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  // A restarted word shifts into a zeroed register so no stale bits survive.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    data_n      = data_out;
    out_valid_n = 1'b0;
    frame_err_n = 1'b0;
    cnt_inc     = 1'b0;
    cnt_restart = 1'b0;
    cnt_clear   = 1'b0;

    if (clear) begin
      state_n   = IDLE;
      shreg_n   = '0;
      cnt_clear = 1'b1;
    end else if (in_valid) begin
      unique case (state)
        IDLE: begin
          shreg_n     = shift_in('0, data_in);
          cnt_restart = 1'b1;
          state_n     = RECV;
        end
        RECV: begin
          if (sof) begin
            frame_err_n = 1'b1;
            shreg_n     = shift_in('0, data_in);
            cnt_restart = 1'b1;
          end else if (cnt_tc_c) begin
            data_n      = shift_in(shreg, data_in);
            out_valid_n = 1'b1;
            shreg_n     = '0;
            cnt_clear   = 1'b1;
            state_n     = IDLE;
          end else begin
            shreg_n = shift_in(shreg, data_in);
            cnt_inc = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == RECV);
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: both bit orders driven in parallel, checked against
// constant vectors and a queue-based word-assembly model.
module tb_sipo_rx;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst, clear, in_valid, data_in, sof;

  logic [W-1:0] m_data, l_data;
  logic         m_ov, l_ov, m_busy, l_busy, m_fe, l_fe;
  logic [1:0]   m_cnt, l_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic         bits[$];
  logic [W-1:0] e_msb, e_lsb;
  logic         e_ov, e_fe;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .sof(sof), .data_out(m_data), .out_valid(m_ov), .busy(m_busy),
    .bit_cnt(m_cnt), .frame_err(m_fe));

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .sof(sof), .data_out(l_data), .out_valid(l_ov), .busy(l_busy),
    .bit_cnt(l_cnt), .frame_err(l_fe));

  typedef struct {
    logic       v, d, s, c;
    logic       ov, fe;
    int         cnt;
    logic [3:0] msb, lsb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    e_msb = '0;
    e_lsb = '0;
    e_ov  = 1'b0;
    e_fe  = 1'b0;
  endtask

  // Word assembly from the list of received bits, in arrival order.
  task automatic model_step(input logic v, input logic d, input logic s, input logic c);
    e_ov = 1'b0;
    e_fe = 1'b0;
    if (c) begin
      bits.delete();
    end else if (v) begin
      if (s && bits.size() > 0) begin
        e_fe = 1'b1;
        bits.delete();
      end
      bits.push_back(d);
      if (bits.size() == W) begin
        e_ov = 1'b1;
        for (int i = 0; i < W; i++) begin
          e_msb[W-1-i] = bits[i];
          e_lsb[i]     = bits[i];
        end
        bits.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " msb data_out"},  int'(m_data), int'(e_msb));
    chk({tag, " lsb data_out"},  int'(l_data), int'(e_lsb));
    chk({tag, " msb out_valid"}, int'(m_ov),   int'(e_ov));
    chk({tag, " lsb out_valid"}, int'(l_ov),   int'(e_ov));
    chk({tag, " msb frame_err"}, int'(m_fe),   int'(e_fe));
    chk({tag, " lsb frame_err"}, int'(l_fe),   int'(e_fe));
    chk({tag, " msb busy"},      int'(m_busy), int'(bits.size() != 0));
    chk({tag, " lsb busy"},      int'(l_busy), int'(bits.size() != 0));
    chk({tag, " msb bit_cnt"},   int'(m_cnt),  bits.size());
    chk({tag, " lsb bit_cnt"},   int'(l_cnt),  bits.size());
  endtask

  task automatic step(input logic v, input logic d, input logic s, input logic c,
                      input string tag);
    in_valid = v;
    data_in  = d;
    sof      = s;
    clear    = c;
    @(posedge clk);
    model_step(v, d, s, c);
    #1;
    check_model(tag);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; data_in = 1'b0; sof = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Constant vectors: plan items 1, 3 and 4 run back to back.
    vecs = '{
      '{1,1,1,0, 0,0,1, 4'h0,4'h0}, '{1,1,0,0, 0,0,2, 4'h0,4'h0},
      '{1,1,0,0, 0,0,3, 4'h0,4'h0}, '{1,1,0,0, 1,0,0, 4'hF,4'hF},
      '{0,0,0,0, 0,0,0, 4'hF,4'hF},
      '{1,1,0,0, 0,0,1, 4'hF,4'hF}, '{1,0,0,0, 0,0,2, 4'hF,4'hF},
      '{1,0,0,0, 0,0,3, 4'hF,4'hF}, '{1,0,0,0, 1,0,0, 4'h8,4'h1},
      '{1,0,0,0, 0,0,1, 4'h8,4'h1}, '{1,1,0,0, 0,0,2, 4'h8,4'h1},
      '{1,0,0,0, 0,0,3, 4'h8,4'h1}, '{1,1,0,0, 1,0,0, 4'h5,4'hA},
      '{1,1,0,0, 0,0,1, 4'h5,4'hA}, '{1,0,0,0, 0,0,2, 4'h5,4'hA},
      '{1,1,1,0, 0,1,1, 4'h5,4'hA}, '{1,1,0,0, 0,0,2, 4'h5,4'hA},
      '{1,0,0,0, 0,0,3, 4'h5,4'hA}, '{1,0,0,0, 1,0,0, 4'hC,4'h3}
    };
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl ov", i),   int'(m_ov),   int'(vecs[i].ov));
      chk($sformatf("vec%0d tbl fe", i),   int'(m_fe),   int'(vecs[i].fe));
      chk($sformatf("vec%0d tbl cnt", i),  int'(m_cnt),  vecs[i].cnt);
      chk($sformatf("vec%0d tbl msb", i),  int'(m_data), int'(vecs[i].msb));
      chk($sformatf("vec%0d tbl lsb", i),  int'(l_data), int'(vecs[i].lsb));
    end

    // Bits 0,1,0,1 separated by 3-cycle in_valid gaps.
    begin
      logic [3:0] pat;
      pat = 4'b1010;
      for (int b = 0; b < 4; b++) begin
        step(1'b1, pat[b], 1'b0, 1'b0, $sformatf("gap bit%0d", b));
        for (int g = 0; g < 3 && b < 3; g++) begin
          step(1'b0, 1'b1, 1'b1, 1'b0, $sformatf("gap%0d.%0d", b, g));
          chk("gap cnt hold", int'(m_cnt), b + 1);
        end
      end
      chk("gap word msb", int'(m_data), 4'h5);
      chk("gap word lsb", int'(l_data), 4'hA);
    end

    // Asynchronous reset in the middle of a cycle with 3 bits held.
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar b0");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ar b2");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model("async rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, "post rst b0");
    step(1'b1, 1'b1, 1'b0, 1'b0, "post rst b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "post rst b2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post rst b3");
    chk("post rst word", int'(m_data), 4'h6);

    // clear with a valid bit: the bit is dropped and data_out keeps 4'h6.
    step(1'b1, 1'b1, 1'b0, 1'b0, "clr b0");
    step(1'b1, 1'b1, 1'b0, 1'b0, "clr b1");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr");
    chk("clr cnt", int'(m_cnt), 0);
    chk("clr fe", int'(m_fe), 0);
    chk("clr data", int'(m_data), 4'h6);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(1'(($urandom_range(0, 9)) < 7), 1'($urandom_range(0, 1)),
           1'(($urandom_range(0, 9)) == 0), 1'(($urandom_range(0, 19)) == 0),
           $sformatf("rnd%0d", n));
      chk("rnd ov/fe exclusive", int'(m_ov & m_fe), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
